mfp_ahb_uart_tx: RTL and testbench
==================================

Name: mfp_ahb_uart_tx

Overview:
- AHB-Lite slave peripheral, the transmit counterpart to the board's UART receive/loader path.
- Software writes bytes over the bus into a TX FIFO; the block serializes them on UART_TX as 8N1 frames.
- Sits as one more memory-mapped I/O slave decoded by the system bus, alongside the switch/LED/7-segment/cube slaves.

Parameters:
- CLK_FREQ, 50000000, HCLK frequency in Hz.
- BAUD, 115200, bit rate. DIV = CLK_FREQ/BAUD (integer floor) HCLK cycles per bit; DIV >= 2 required.
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2, 2..256.

Ports:
- HCLK  in  1  system clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from the bus address decoder.
- HADDR  in  4  byte offset within the slave window.
- HTRANS  in  2  AHB transfer type; bit1 = 1 (NONSEQ/SEQ) is a valid transfer.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, data phase.
- HRDATA  out  32  read data, data phase.
- HREADY  out  1  tied to 1; zero wait states.
- HRESP  out  1  tied to 0 (OKAY).
- UART_TX  out  1  serial output; idle high.
- TX_IRQ  out  1  level: FIFO empty AND serializer idle.

Behaviour:
- Reset, one HCLK with HRESET=1, clears:
  - UART_TX=1, HRDATA=0, TX_IRQ=1 after reset.
  - FIFO empty; serializer in IDLE; overflow flag 0; address-phase registers cleared.
  - Reset mid-frame aborts the frame immediately: UART_TX returns to 1 the next cycle and FIFO contents are lost.
- Address phase: when HSEL & HTRANS[1], register HADDR[3:2] and HWRITE as a pending access. The data phase is the following cycle.
- Register map (word offsets):
  - 0x0 DATA. Write: push HWDATA[7:0]. Read: 0.
  - 0x4 STATUS, read:
    - bit0 busy (serializer not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow
    - bits[16:8] FIFO level, 0..FIFO_DEPTH
    - other bits 0
  - 0x4 STATUS, write: writing 1 to bit3 clears overflow; other bits ignored.
  - 0x8, 0xC: reads return 0, writes are ignored.
- HRDATA is registered, valid during the data phase. HSIZE is not decoded; byte, half and word writes to DATA all push HWDATA[7:0].
- FIFO:
  - A push takes effect at the end of the data-phase cycle.
  - The push is accepted when the FIFO is not full, or when it is full and a pop happens in the same cycle; level is then unchanged.
  - A push while full without a pop drops the byte and sets overflow (sticky).
  - Read and write pointers wrap modulo FIFO_DEPTH; level is tracked separately so full and empty are unambiguous.
- Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: UART_TX=1. If the FIFO is not empty, pop the head into the shift register, go to START, and clear the bit counter.
  - START: UART_TX=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each; shift right at each bit end.
  - STOP: UART_TX=1 for DIV cycles. At the end of STOP, if the FIFO is not empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
  - Frame length is exactly 10*DIV cycles.
- Latency:
  - DATA write data phase in cycle N: entry is visible in cycle N+1.
  - If IDLE, the pop happens in cycle N+1 and UART_TX falls in cycle N+2.
- UART_TX is driven from a flop; no glitches.
- The baud counter runs 0..DIV-1 and resets at each state entry.
- A STATUS read in the same data phase as a push reflects the pre-push state.

Test Plan:
- Reset: hold HRESET 3 cycles -> UART_TX=1, STATUS read = 0x00000004, TX_IRQ=1.
- Single byte, CLK_FREQ=1000000, BAUD=100000 (DIV=10): write 0x000000A5 to 0x0 ->
  - UART_TX falls 2 cycles after the data phase;
  - samples at bit centres read 0,1,0,1,0,0,1,0,1,1;
  - frame is 100 cycles; TX_IRQ=1 afterwards.
- Back-to-back: write 0x55 then 0x0F in consecutive cycles ->
  - two frames, 200 contiguous cycles, with no idle high between the first stop bit and the second start bit;
  - STATUS busy=1 throughout.
- Overflow, FIFO_DEPTH=4:
  - 6 writes 0x01..0x06 in consecutive cycles -> first byte popped, 4 buffered, 0x06 dropped.
  - STATUS = level 4, full=1, overflow=1.
  - Write 0x8 to STATUS -> overflow=0.
  - Only 0x01..0x05 appear on UART_TX.
- Full with simultaneous pop: with the FIFO full, time a write to coincide with the end of STOP -> byte accepted, level stays FIFO_DEPTH, overflow stays 0.
- Reset mid-frame: assert HRESET during DATA bit 3 -> next cycle UART_TX=1, STATUS=0x00000004, no further frame output.

Source files
------------

// File: rtl/mfp_ahb_uart_tx.sv
// mfp_ahb_uart_tx
// AHB-Lite slave that buffers bytes written by software in a TX FIFO and
// sends them on UART_TX as 8N1 frames (1 start, 8 data LSB first, 1 stop).
//
// Ports:
//   HCLK    - system clock, all logic on the rising edge
//   HRESET  - synchronous active-high reset
//   HSEL    - slave select from the bus address decoder
//   HADDR   - byte offset in the slave window (word offsets 0x0..0xC)
//   HTRANS  - transfer type, bit1 set marks a valid transfer
//   HWRITE  - 1 = write
//   HWDATA  - write data (data phase)
//   HRDATA  - registered read data (data phase)
//   HREADY  - always 1, zero wait states
//   HRESP   - always 0, OKAY
//   UART_TX - serial output, idle high
//   TX_IRQ  - level, FIFO empty and serializer idle
//
// Register map: 0x0 DATA (write pushes HWDATA[7:0]), 0x4 STATUS
// (bit0 busy, bit1 full, bit2 empty, bit3 overflow (write 1 clears),
// bits[16:8] level), 0x8/0xC read as zero.
module mfp_ahb_uart_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic        UART_TX,
  output logic        TX_IRQ
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // bus pipeline
  logic              pend_valid_r;
  logic              pend_write_r;
  logic [1:0]        pend_addr_r;
  logic              push_req_s;
  logic              ovf_clr_s;
  logic [31:0]       status_s;
  logic [31:0]       rdata_s;
  logic [31:0]       hrdata_r;

  // FIFO
  logic [7:0]        fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_next_s;
  logic              full_s;
  logic              empty_s;
  logic              push_ok_s;
  logic              ovf_set_s;
  logic              ovf_r;

  // serializer
  tx_state_t         state_r;
  tx_state_t         state_next_s;
  logic [CNT_W-1:0]  baud_cnt_r;
  logic [CNT_W-1:0]  baud_cnt_next_s;
  logic [2:0]        bit_cnt_r;
  logic [2:0]        bit_cnt_next_s;
  logic [7:0]        shift_r;
  logic [7:0]        shift_next_s;
  logic              bit_end_s;
  logic              pop_s;
  logic              tx_r;
  logic              tx_next_s;
  logic              irq_r;

  logic              unused_s;
  assign unused_s = ^{HADDR[1:0], HWDATA[31:8]};

  assign HREADY  = 1'b1;
  assign HRESP   = 1'b0;
  assign HRDATA  = hrdata_r;
  assign UART_TX = tx_r;
  assign TX_IRQ  = irq_r;

  // Capture the address phase so the write can be decoded in the data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_valid_r <= 1'b0;
      pend_write_r <= 1'b0;
      pend_addr_r  <= 2'd0;
    end else begin
      pend_valid_r <= HSEL & HTRANS[1];
      pend_write_r <= HWRITE;
      pend_addr_r  <= HADDR[3:2];
    end
  end

  // Decode data-phase writes: DATA push and overflow clear.
  always_comb begin
    push_req_s = 1'b0;
    ovf_clr_s  = 1'b0;
    if (pend_valid_r && pend_write_r) begin
      case (pend_addr_r)
        2'd0:    push_req_s = 1'b1;
        2'd1:    ovf_clr_s  = HWDATA[3];
        default: begin
          push_req_s = 1'b0;
          ovf_clr_s  = 1'b0;
        end
      endcase
    end else begin
      push_req_s = 1'b0;
      ovf_clr_s  = 1'b0;
    end
  end

  // FIFO flags and level update; a push while full is accepted only if a
  // pop frees the slot in the same cycle.
  always_comb begin
    full_s       = (level_r == LVL_FULL);
    empty_s      = (level_r == LVL_ZERO);
    push_ok_s    = push_req_s & (~full_s | pop_s);
    ovf_set_s    = push_req_s & full_s & ~pop_s;
    level_next_s = level_r;
    case ({push_ok_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge HCLK) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= HWDATA[7:0];
    end
  end

  // FIFO pointers (wrap naturally at the power-of-2 depth), level, overflow.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= LVL_ZERO;
      ovf_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r <= level_next_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Serializer next state; the pop at the end of STOP chains frames with no gap.
  always_comb begin
    state_next_s    = state_r;
    baud_cnt_next_s = baud_cnt_r + CNT_W'(1);
    bit_cnt_next_s  = bit_cnt_r;
    shift_next_s    = shift_r;
    pop_s           = 1'b0;
    bit_end_s       = (baud_cnt_r == CNT_LAST);
    case (state_r)
      ST_IDLE: begin
        baud_cnt_next_s = {CNT_W{1'b0}};
        if (!empty_s) begin
          pop_s          = 1'b1;
          shift_next_s   = fifo_mem_r[rd_ptr_r];
          bit_cnt_next_s = 3'd0;
          state_next_s   = ST_START;
        end else begin
          state_next_s   = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_cnt_next_s = {CNT_W{1'b0}};
          state_next_s    = ST_DATA;
        end else begin
          state_next_s    = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_cnt_next_s = {CNT_W{1'b0}};
          shift_next_s    = {1'b0, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_next_s   = ST_STOP;
          end else begin
            bit_cnt_next_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          baud_cnt_next_s = {CNT_W{1'b0}};
          if (!empty_s) begin
            pop_s          = 1'b1;
            shift_next_s   = fifo_mem_r[rd_ptr_r];
            bit_cnt_next_s = 3'd0;
            state_next_s   = ST_START;
          end else begin
            state_next_s   = ST_IDLE;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        baud_cnt_next_s = {CNT_W{1'b0}};
        state_next_s    = ST_IDLE;
      end
    endcase
  end

  // Line level and IRQ are computed from next-state values so the flops
  // line up with the state they describe.
  always_comb begin
    tx_next_s = 1'b1;
    case (state_next_s)
      ST_START: tx_next_s = 1'b0;
      ST_DATA:  tx_next_s = shift_next_s[0];
      default:  tx_next_s = 1'b1;
    endcase
  end

  // Serializer registers and registered outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      tx_r       <= 1'b1;
      irq_r      <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      baud_cnt_r <= baud_cnt_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      shift_r    <= shift_next_s;
      tx_r       <= tx_next_s;
      irq_r      <= (level_next_s == LVL_ZERO) && (state_next_s == ST_IDLE);
    end
  end

  // Read mux, sampled in the address phase so a STATUS read sees the
  // state before any push completing in its data phase.
  always_comb begin
    status_s       = 32'd0;
    status_s[16:8] = 9'(level_r);
    status_s[3:0]  = {ovf_r, empty_s, full_s, (state_r != ST_IDLE)};
    if (HSEL && HTRANS[1] && !HWRITE && (HADDR[3:2] == 2'd1)) begin
      rdata_s = status_s;
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Registered read data, presented during the data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hrdata_r <= 32'd0;
    end else begin
      hrdata_r <= rdata_s;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// tb_mfp_ahb_uart_tx
// Directed bench for mfp_ahb_uart_tx with DIV=10 and a 4-entry FIFO.
// Bytes expected on the line are queued when written; a line monitor
// decodes every frame at bit centres and pops/compares them.
module tb_mfp_ahb_uart_tx;

  localparam int DIV = 10;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [3:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        UART_TX;
  logic        TX_IRQ;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [7:0]  sb[$];
  int          starts[$];
  int          frames_done = 0;

  mfp_ahb_uart_tx #(
    .CLK_FREQ   (1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .HSEL    (HSEL),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA),
    .HREADY  (HREADY),
    .HRESP   (HRESP),
    .UART_TX (UART_TX),
    .TX_IRQ  (TX_IRQ)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  // Single write; dp returns the data-phase cycle.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int dp);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    dp = cyc;
    tick();
  endtask

  // Single read; returns in the data-phase cycle with the sampled data.
  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  // Pipelined writes in consecutive cycles to one address.
  task automatic write_burst(input logic [3:0] a, input logic [7:0] b [8], input int n,
                             output int first_dp);
    first_dp = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1;
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      end
      if (i > 0) HWDATA = {24'd0, b[i-1]};
      if (i == 1) first_dp = cyc;
      tick();
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int b;
    b = budget;
    while (frames_done < target && b > 0) begin
      tick();
      b--;
    end
    check("frame_timeout", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic wait_start(input int target, input int budget);
    int b;
    b = budget;
    while (starts.size() < target && b > 0) begin
      tick();
      b--;
    end
    check("start_timeout", 32'(starts.size() >= target), 32'd1);
  endtask

  // Line monitor: samples at negedge, decodes frames at bit centres.
  initial begin
    bit         mon_active;
    int         mon_cnt;
    int         k;
    logic [7:0] mon_byte;
    logic [31:0] exp_v;
    mon_active = 1'b0;
    mon_cnt    = 0;
    mon_byte   = 8'd0;
    forever begin
      @(negedge HCLK);
      if (HRESET === 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (UART_TX === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          starts.push_back(cyc);
        end
      end else begin
        mon_cnt++;
      end
      if (mon_active && (mon_cnt % DIV) == DIV / 2) begin
        k = mon_cnt / DIV;
        if (k == 0) begin
          check("start_bit", {31'd0, UART_TX}, 32'd0);
        end else if (k <= 8) begin
          mon_byte[k-1] = UART_TX;
        end else begin
          check("stop_bit", {31'd0, UART_TX}, 32'd1);
          if (sb.size() != 0) exp_v = {24'd0, sb.pop_front()};
          else exp_v = 32'hDEADBEEF;
          check("frame_byte", {24'd0, mon_byte}, exp_v);
          frames_done++;
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  bv [8];
    int          dp;
    int          s;
    int          nf;
    int          nd;

    HRESET = 1'b1; HSEL = 1'b0; HADDR = 4'd0; HTRANS = 2'b00;
    HWRITE = 1'b0; HWDATA = 32'd0;
    for (int i = 0; i < 8; i++) bv[i] = 8'd0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // reset state
    check("rst_tx", {31'd0, UART_TX}, 32'd1);
    check("rst_irq", {31'd0, TX_IRQ}, 32'd1);
    check("rst_hrdata", HRDATA, 32'd0);
    check("hready", {31'd0, HREADY}, 32'd1);
    check("hresp", {31'd0, HRESP}, 32'd0);
    bus_read(4'h4, rd);
    check("rst_status", rd, 32'h00000004);
    bus_read(4'h0, rd);
    check("data_read_zero", rd, 32'd0);
    bus_read(4'hC, rd);
    check("reg_c_read_zero", rd, 32'd0);
    bus_write(4'h8, 32'h000000FF, dp);
    bus_read(4'h4, rd);
    check("reg8_write_ignored", rd, 32'h00000004);

    // single byte 0xA5
    nf = starts.size();
    sb.push_back(8'hA5);
    bus_write(4'h0, 32'h000000A5, dp);
    check("irq_after_push", {31'd0, TX_IRQ}, 32'd0);
    repeat (20) tick();
    bus_read(4'h4, rd);
    check("status_busy_single", rd, 32'h00000005);
    wait_done(frames_done + 1, 300);
    s = starts[nf];
    check("fall_latency", 32'(s), 32'(dp + 2));
    wait_cyc(s + 99);
    check("stop_last_cycle_irq", {31'd0, TX_IRQ}, 32'd0);
    tick();
    check("frame_end_irq", {31'd0, TX_IRQ}, 32'd1);
    check("frame_end_tx", {31'd0, UART_TX}, 32'd1);

    // back-to-back 0x55, 0x0F
    nf = starts.size();
    nd = frames_done;
    bv[0] = 8'h55; bv[1] = 8'h0F;
    sb.push_back(8'h55); sb.push_back(8'h0F);
    write_burst(4'h0, bv, 2, dp);
    for (int i = 0; i < 9; i++) begin
      repeat (19) tick();
      bus_read(4'h4, rd);
      check("b2b_busy", {31'd0, rd[0]}, 32'd1);
    end
    wait_done(nd + 2, 400);
    check("b2b_latency", 32'(starts[nf]), 32'(dp + 2));
    check("b2b_contiguous", 32'(starts[nf+1] - starts[nf]), 32'd100);

    // overflow with a 4-deep FIFO
    wait_cyc(starts[starts.size()-1] + 110);
    nf = starts.size();
    nd = frames_done;
    for (int i = 0; i < 6; i++) bv[i] = 8'(i + 1);
    for (int i = 0; i < 5; i++) sb.push_back(8'(i + 1));
    write_burst(4'h0, bv, 6, dp);
    bus_read(4'h4, rd);
    check("ovf_status", rd, 32'h0000040B);
    bus_write(4'h4, 32'h00000008, dp);
    bus_read(4'h4, rd);
    check("ovf_cleared", rd, 32'h00000403);
    check("ovf_irq", {31'd0, TX_IRQ}, 32'd0);

    // full FIFO, write lands on the pop at the end of STOP
    s = starts[nf];
    wait_cyc(s + 98);
    sb.push_back(8'h77);
    bus_write(4'h0, 32'h00000077, dp);
    check("full_pop_dp", 32'(dp), 32'(s + 99));
    bus_read(4'h4, rd);
    check("full_pop_status", rd, 32'h00000403);
    wait_done(nd + 6, 800);
    wait_cyc(starts[starts.size()-1] + 100);
    check("drain_irq", {31'd0, TX_IRQ}, 32'd1);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    bus_read(4'h4, rd);
    check("drain_status", rd, 32'h00000004);

    // reset during data bit 3
    nf = starts.size();
    bv[0] = 8'hC3; bv[1] = 8'h3C;
    sb.push_back(8'hC3); sb.push_back(8'h3C);
    write_burst(4'h0, bv, 2, dp);
    wait_start(nf + 1, 50);
    s = starts[starts.size()-1];
    wait_cyc(s + 44);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    sb.delete();
    check("midrst_tx", {31'd0, UART_TX}, 32'd1);
    check("midrst_irq", {31'd0, TX_IRQ}, 32'd1);
    bus_read(4'h4, rd);
    check("midrst_status", rd, 32'h00000004);
    nf = starts.size();
    repeat (300) tick();
    check("midrst_no_frame", 32'(starts.size()), 32'(nf));
    check("midrst_tx_idle", {31'd0, UART_TX}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
